serial_add_ctrl: RTL and testbench

- Bit-serial adder/subtractor controller. It sequences one 1-bit full-adder slice (SO = A^B^CI, CO = A&B | (A^B)&CI) over WIDTH cycles, LSB first, to produce a WIDTH-bit sum.
- Used in the lab datapath where area matters more than latency.
- Provides a start/busy/done handshake toward the control unit and registered result flags.

---
 rtl/serial_add_ctrl.sv | 171 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder/subtractor. One 1-bit full-adder slice is stepped over
//   WIDTH clock cycles, LSB first, and builds a WIDTH-bit result.
//   Subtraction is done as A + ~B + 1. The control unit uses a
//   start/busy/done handshake. The result flags are registered and change
//   only when an operation completes.
//
// Parameters
//   WIDTH  operand/result width, 2..32
//   CNT_W  bit-counter width, 2**CNT_W must be greater than WIDTH
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new operation; sampled only when not busy
//   op_sub  in   0: a+b+ci   1: a-b
//   a, b    in   operands, sampled together with start
//   ci      in   carry-in for add; ignored for subtract
//   busy    out  high while the slice is running
//   done    out  one-cycle pulse when sum/co/ovf are updated
//   sum     out  registered result (modulo 2**WIDTH)
//   co      out  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ovf     out  signed overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;

  // Full-adder slice. Outside RUN its inputs are forced to 0, so no X from an
  // unloaded operand register can reach the adder.
  logic slice_a, slice_b, slice_ci, slice_so, slice_co;
  logic last_bit;

  assign slice_a  = (state_q == RUN) ? opa_q[0] : 1'b0;
  assign slice_b  = (state_q == RUN) ? opb_q[0] : 1'b0;
  assign slice_ci = (state_q == RUN) ? carry_q  : 1'b0;
  assign slice_so = slice_a ^ slice_b ^ slice_ci;
  assign slice_co = (slice_a & slice_b) | ((slice_a ^ slice_b) & slice_ci);

  // The count already equals WIDTH-1 while the MSB is in the slice.
  // At that point carry_q is the carry entering the MSB.
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    // NOTE: every signal gets a default first. A path that does not assign a
    // signal would then infer a latch, and this prevents that.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE takes a new start exactly like IDLE. This gives back-to-back
        // operations with no idle gap.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          opa_d   = a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : ci;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {slice_so, res_q[WIDTH-1:1]};
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {slice_so, res_q[WIDTH-1:1]};
          co_d    = slice_co;
          // Signed overflow is the carry into the MSB XOR the carry out of it.
          ovf_d   = carry_q ^ slice_co;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: every register, including the operand and result shift registers,
  // is cleared by the asynchronous reset. An aborted operation then leaves no
  // stale data behind. These are a few flops, not a RAM, so the reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. All flops sample their _d values from
      // the same edge, whatever order the statements are written in.
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl with WIDTH=8. The stimulus pushes the
//   hand-computed result and the expected done cycle into a scoreboard queue.
//   A monitor pops one entry on every done pulse and compares it.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    int               cyc;
    string            name;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .ci     (ci),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .co     (co),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 required 0", cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_sum"},   32'(sum),  32'(e.sum));
        check({e.name, "_co"},    32'(co),   32'(e.co));
        check({e.name, "_ovf"},   32'(ovf),  32'(e.ovf));
        check({e.name, "_cycle"}, 32'(cycle), 32'(e.cyc));
      end
    end
  end

  // The caller is at a falling edge. Drive the operands with start=1 and
  // record the expected result. The sampling edge comes next (cycle+1), and
  // done is due WIDTH cycles after it.
  task automatic issue(input string name, input logic sub_i,
                       input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                       input logic ci_i, input logic [WIDTH-1:0] e_sum,
                       input logic e_co, input logic e_ovf);
    exp_t e;
    start  = 1'b1;
    op_sub = sub_i;
    a      = a_i;
    b      = b_i;
    ci     = ci_i;
    e.sum  = e_sum;
    e.co   = e_co;
    e.ovf  = e_ovf;
    e.cyc  = cycle + 1 + WIDTH;
    e.name = name;
    sb.push_back(e);
  endtask

  // Wait with a bound until the scoreboard has drained.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    ci     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_sum",  32'(sum),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // First add: also check the busy window. Busy must be high on the 8
    // falling edges after T0 and low on the falling edge where done shows.
    issue("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("busy_run_%0d", i), 32'(busy), 1);
      @(negedge clk);
    end
    check("busy_at_done", 32'(busy), 0);
    drain("add_5a_3c");
    @(negedge clk);

    issue("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("add_ff_01");
    @(negedge clk);

    issue("add_ff_01_ci", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("add_ff_01_ci");
    @(negedge clk);

    issue("sub_10_20", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("sub_10_20");
    @(negedge clk);

    // Sum/co/ovf must hold the previous result through the next RUN.
    issue("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("hold_sum_in_run", 32'(sum), 32'h0F0);
    drain("sub_80_01");
    @(negedge clk);

    // A start pulse during RUN cycle 3 with new operands must be ignored.
    issue("ignore_start", 1'b0, 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    op_sub = 1'b1;
    a      = 8'hAA;
    b      = 8'h55;
    ci     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_start");
    @(negedge clk);

    // Back-to-back: start is held in the DONE cycle, so the second done
    // comes 9 cycles after the first.
    issue("b2b_first", 1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_seen", 32'(done), 1);
    end
    issue("b2b_second", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 0);
    check("b2b_busy",      32'(busy), 1);
    drain("b2b_second");
    @(negedge clk);

    // Reset during RUN. Rst_n goes low between edges in RUN cycle 4. Outputs
    // must clear at once, and this operation never reports.
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 8'h40;
    b      = 8'h40;
    ci     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_sum",  32'(sum),  0);
    check("rst_mid_co",   32'(co),   0);
    check("rst_mid_ovf",  32'(ovf),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle_done", 32'(done), 0);

    issue("add_after_rst", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("add_after_rst");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
